mix_columns_engine: RTL and testbench

- Sequential, handshaked MixColumns / InvMixColumns engine for the 128-bit AES state matrix.
- Processes COLS_PER_CYCLE columns per clock, so one datapath trades area against latency across cipher variants.
- Sits between ShiftRows and AddRoundKey in the iterative round datapath.
- Adds the inverse transform for the decryption path, selected per transaction.

---
 rtl/mix_columns_engine.sv | 176 +++++++++++++++++
 tb/tb_mix_columns_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_engine
// Purpose  : Handshaked AES MixColumns / InvMixColumns engine operating on the
//            128-bit state matrix, COLS_PER_CYCLE columns per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   COLS_PER_CYCLE - columns transformed per clock (1, 2 or 4)
// Ports:
//   clk        in   1    system clock, rising edge
//   reset_n    in   1    asynchronous active-low reset
//   in_valid   in   1    in_state / in_inv valid
//   in_ready   out  1    engine can accept a state this cycle
//   in_state   in   128  column c = bits [127-32c -: 32], byte 0 in MSBs
//   in_inv     in   1    0 = MixColumns, 1 = InvMixColumns
//   out_valid  out  1    out_state holds a finished result
//   out_ready  in   1    downstream accepts out_state
//   out_state  out  128  transformed state, same ordering as in_state
//   busy       out  1    high while columns are being transformed
// ============================================================================
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Number of RUN cycles per state; guarded so an illegal width still
  // elaborates far enough to report the error above.
  localparam int         N_RUN  = (COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
                                   COLS_PER_CYCLE == 4) ? (4 / COLS_PER_CYCLE) : 1;
  localparam logic [1:0] LAST_K = 2'(N_RUN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   k;          // column-group counter within RUN
  logic [127:0] work;       // working register, transformed in place
  logic         inv;        // latched transform direction
  logic         accept;
  logic [127:0] work_next;

  // GF(2^8) multiply by x, reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column. The inverse is factored as a cheap {05,00,04,00}
  // premultiply followed by the forward transform, so both directions
  // share the same XOR network.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv_mode);
    logic [7:0] a0, a1, a2, a3, u, v, t;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv_mode) begin
      u  = xt(xt(a0 ^ a2));
      v  = xt(xt(a1 ^ a3));
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xt(a0 ^ a1),
            a1 ^ t ^ xt(a1 ^ a2),
            a2 ^ t ^ xt(a2 ^ a3),
            a3 ^ t ^ xt(a3 ^ a0)};
  endfunction

  // Column lanes: lane j handles column k*COLS_PER_CYCLE + j.
  logic [1:0]  lane_col [COLS_PER_CYCLE];
  logic [31:0] lane_in  [COLS_PER_CYCLE];
  logic [31:0] lane_out [COLS_PER_CYCLE];

  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      assign lane_col[j] = 2'(int'(k) * COLS_PER_CYCLE + j);
      assign lane_in[j]  = work[127 - 32*lane_col[j] -: 32];
      assign lane_out[j] = mix_column(lane_in[j], inv);
    end
  endgenerate

  always_comb begin
    work_next = work;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      work_next[127 - 32*lane_col[j] -: 32] = lane_out[j];
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (k == LAST_K) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Hand-off and new accept can share a cycle: no IDLE bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k    <= 2'd0;
      work <= 128'd0;
      inv  <= 1'b0;
    end else if (accept) begin
      k    <= 2'd0;
      work <= in_state;
      inv  <= in_inv;
    end else if (state == RUN) begin
      k    <= k + 2'd1;
      work <= work_next;
    end
  end

  assign out_state = work;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_engine
// Purpose  : Self-checking bench for mix_columns_engine; one instance per
//            legal COLS_PER_CYCLE (1, 2, 4) sharing the input side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic [127:0] in_state = 128'd0;
  logic         out_ready = 1'b1;

  // Index 0: COLS_PER_CYCLE=1, 1: =2, 2: =4 (N = 4 >> index)
  logic         rdy  [3];
  logic         ovld [3];
  logic         bsy  [3];
  logic [127:0] ost  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [2:0] mon_en = 3'b111;

  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];
  logic [127:0] sb_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ovld[0]),
    .out_ready(out_ready), .out_state(ost[0]), .busy(bsy[0]));

  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ovld[1]),
    .out_ready(out_ready), .out_state(ost[1]), .busy(bsy[1]));

  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ovld[2]),
    .out_ready(out_ready), .out_state(ost[2]), .busy(bsy[2]));

  // Reference model: generic GF(2^8) matrix multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   y;
    logic [127:0] r;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) a[b] = s[127 - 32*c - 8*b -: 8];
      for (int row = 0; row < 4; row++) begin
        y = 8'h00;
        for (int cc = 0; cc < 4; cc++) y = y ^ gmul(m[(cc - row + 4) % 4], a[cc]);
        r[127 - 32*c - 8*row -: 8] = y;
      end
    end
    return r;
  endfunction

  // Scoreboard monitors: compare every output handshake against the queue.
  always @(negedge clk) begin
    if (mon_en[0] && ovld[0] && out_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb_cpc1 unexpected output got %h want none", ost[0]);
      end else begin
        sb_exp = q0.pop_front();
        if (ost[0] !== sb_exp) begin
          errors++;
          $display("FAIL sb_cpc1 out_state got %h want %h", ost[0], sb_exp);
        end
      end
    end
    if (mon_en[1] && ovld[1] && out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb_cpc2 unexpected output got %h want none", ost[1]);
      end else begin
        sb_exp = q1.pop_front();
        if (ost[1] !== sb_exp) begin
          errors++;
          $display("FAIL sb_cpc2 out_state got %h want %h", ost[1], sb_exp);
        end
      end
    end
    if (mon_en[2] && ovld[2] && out_ready) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb_cpc4 unexpected output got %h want none", ost[2]);
      end else begin
        sb_exp = q2.pop_front();
        if (ost[2] !== sb_exp) begin
          errors++;
          $display("FAIL sb_cpc4 out_state got %h want %h", ost[2], sb_exp);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_state  = 128'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending got %0d/%0d/%0d want 0/0/0", name,
               q0.size(), q1.size(), q2.size());
    end
  endtask

  // One transaction into all three engines (all must be idle); checks that
  // out_valid first rises exactly N cycles after the accept edge.
  task automatic run_all(input logic [127:0] st, input logic inv, input logic [127:0] exp);
    int first [3];
    for (int i = 0; i < 3; i++) first[i] = -1;
    q0.push_back(exp);
    q1.push_back(exp);
    q2.push_back(exp);
    in_state = st;
    in_inv   = inv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (ovld[i] && first[i] < 0) first[i] = c;
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] != (4 >> i)) begin
        errors++;
        $display("FAIL latency_n%0d got %0d want %0d", 4 >> i, first[i], 4 >> i);
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks += 4;
      if (rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready idx%0d got %b want 1", i, rdy[i]); end
      if (ovld[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid idx%0d got %b want 0", i, ovld[i]); end
      if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy idx%0d got %b want 0", i, bsy[i]); end
      if (ost[i] !== 128'd0) begin errors++; $display("FAIL reset_out_state idx%0d got %h want 0", i, ost[i]); end
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_fips();
    run_all(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    run_all(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
            128'hdb135345_f20a225c_01010101_c6c6c6c6);
    run_all(128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0,
            128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);
    check_drained("fips");
  endtask

  task automatic test_round_trip();
    logic [127:0] st, f;
    for (int n = 0; n < 1000; n++) begin
      st = {$urandom(), $urandom(), $urandom(), $urandom()};
      f  = model(st, 1'b0);
      run_all(st, 1'b0, f);
      run_all(f, 1'b1, st);
    end
    check_drained("round_trip");
  endtask

  task automatic test_backpressure();
    logic [127:0] s1, s2, e1;
    int t;
    do_reset();
    s1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    s2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    e1 = model(s1, 1'b0);
    out_ready = 1'b0;
    q0.push_back(e1); q1.push_back(e1); q2.push_back(e1);
    in_state = s1; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    t = 0;
    while (!ovld[0] && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL bp_wait_done got timeout want out_valid");
    end
    // Offer a new state during the stall; it must not be taken.
    in_state = s2; in_inv = 1'b1; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checks += 3;
      if (ovld[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", ovld[0]); end
      if (ost[0] !== e1) begin errors++; $display("FAIL bp_out_state got %h want %h", ost[0], e1); end
      if (rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", rdy[0]); end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    q0.push_back(model(s2, 1'b1)); q1.push_back(model(s2, 1'b1)); q2.push_back(model(s2, 1'b1));
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_handoff_in_ready got %b want 1", rdy[0]); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bsy[0] !== 1'b1) begin errors++; $display("FAIL bp_busy_after got %b want 1", bsy[0]); end
    if (ovld[0] !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after got %b want 0", ovld[0]); end
    repeat (6) @(posedge clk);
    #1;
    check_drained("backpressure");
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] s3;
    do_reset();
    mon_en = 3'b000;
    in_state = 128'hffeeddcc_bbaa9988_77665544_33221100;
    in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bsy[0] !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", bsy[0]); end
    #2 reset_n = 1'b0;
    #1;
    checks += 4;
    if (ovld[0] !== 1'b0) begin errors++; $display("FAIL midrun_out_valid got %b want 0", ovld[0]); end
    if (ost[0] !== 128'd0) begin errors++; $display("FAIL midrun_out_state got %h want 0", ost[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrun_in_ready got %b want 1", rdy[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL midrun_busy_rst got %b want 0", bsy[0]); end
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 3'b111;
    s3 = 128'h3243f6a8_885a308d_313198a2_e0370734;
    run_all(s3, 1'b0, model(s3, 1'b0));
    check_drained("reset_mid_run");
  endtask

  task automatic test_back_to_back();
    int acc_cyc [8];
    logic [127:0] st;
    logic inv;
    logic got;
    int t;
    do_reset();
    mon_en = 3'b010;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      st  = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv = 1'($urandom_range(0, 1));
      q1.push_back(model(st, inv));
      in_state = st;
      in_inv   = inv;
      t = 0;
      do begin
        @(negedge clk);
        got = rdy[1];
        @(posedge clk);
        #1;
        t++;
      end while (!got && t < 10);
      acc_cyc[s] = cyc;
      if (!got) begin
        checks++; errors++;
        $display("FAIL stream_accept_%0d got timeout want accept", s);
      end
    end
    in_valid = 1'b0;
    for (int s = 1; s < 8; s++) begin
      checks++;
      if (acc_cyc[s] - acc_cyc[s-1] != 3) begin
        errors++;
        $display("FAIL stream_spacing_%0d got %0d want 3", s, acc_cyc[s] - acc_cyc[s-1]);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    check_drained("back_to_back");
    do_reset();
    q0.delete(); q2.delete();
    mon_en = 3'b111;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_round_trip();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
